// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains a synchronous FIFO that has a one-cycle read latency and re-presents
// its words as a valid/ready stream. A two-entry output buffer plus a one-bit
// "read in flight" flag let the block sustain one word per cycle while m_ready
// stays high, and keep it from overrunning when the consumer stalls.
//
// Optional feature (macro FIFO_RDR_STATS_EN):
//   When defined, a 16-bit word_count port counts every delivered word.
//   The counter wraps from 0xFFFF to 0x0000.
//
// Ports
//   clk          in   single rising-edge clock, shared with the FIFO
//   rst          in   asynchronous active-high reset
//   fifo_empty   in   FIFO empty flag
//   fifo_dout    in   FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en   out  FIFO read request (combinational)
//   m_valid      out  stream word available (registered)
//   m_data       out  stream word, head of the output buffer (registered)
//   m_ready      in   consumer accepts m_data when high with m_valid
//   word_count   out  delivered-word counter (FIFO_RDR_STATS_EN only)
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RDR_STATS_EN
    ,
    output logic [15:0]           word_count
`endif
);

    localparam int unsigned OCC_W   = 2;
    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned CNT_W   = 16;

    // Registered state
    logic [OCC_W-1:0]      r_occ;
    logic                  r_inflight;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    // Next-state / combinational helpers
    logic                  w_pop;
    logic [OCC_W-1:0]      w_after_pop;
    logic [LEVEL_W-1:0]    w_level;
    logic                  w_rd_en;
    logic [OCC_W-1:0]      w_occ_nxt;
    logic                  w_valid_nxt;
    logic [DATA_WIDTH-1:0] w_buf0_nxt;
    logic [DATA_WIDTH-1:0] w_buf1_nxt;

    // Occupancy bookkeeping and read-request decision
    always_comb begin
        w_pop       = r_valid & m_ready;
        // A pop only happens with r_valid set, i.e. r_occ >= 1, so no underflow.
        w_after_pop = r_occ - OCC_W'(w_pop);
        // Words that will be held once the pop and any in-flight capture land.
        w_level     = LEVEL_W'(r_occ) - LEVEL_W'(w_pop) + LEVEL_W'(r_inflight);
        // Issue a read only if its word is guaranteed a free slot next cycle.
        w_rd_en     = !rst && !fifo_empty && (w_level < LEVEL_W'(2));
        w_occ_nxt   = w_level[OCC_W-1:0];
        w_valid_nxt = (w_occ_nxt != '0);
    end

    // Output buffer update: shift on pop, then capture into first free slot
    always_comb begin
        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        if (w_pop) begin
            w_buf0_nxt = r_buf1;
        end
        if (r_inflight) begin
            if (w_after_pop == '0) begin
                w_buf0_nxt = fifo_dout;
            end else begin
                w_buf1_nxt = fifo_dout;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= w_rd_en;
            r_valid    <= w_valid_nxt;
            r_buf0     <= w_buf0_nxt;
            r_buf1     <= w_buf1_nxt;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = r_valid;
    assign m_data     = r_buf0;

`ifdef FIFO_RDR_STATS_EN
    logic [CNT_W-1:0] r_word_count;

    // Delivered-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count <= '0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + CNT_W'(1);
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
`ifdef FIFO_RDR_STATS_EN
    logic [15:0] word_count;
`endif

    int total = 0;
    int bad   = 0;

    fifo_stream_reader #(.DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef FIFO_RDR_STATS_EN
        ,
        .word_count (word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO with one-cycle read latency. The bench writes mem/wp,
    // the model alone advances rp.
    logic [15:0] mem [0:255];
    int unsigned wp = 0;
    int unsigned rp = 0;

    assign fifo_empty = (wp == rp);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rp        <= wp;
            fifo_dout <= 16'h0;
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[rp % 256];
            rp        <= rp + 1;
        end
    end

    logic [15:0] exp_q [$];
    int rd_cnt  = 0;
    int pop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wp % 256] = w;
        wp = wp + 1;
        exp_q.push_back(w);
    endtask

    // One clock cycle: per-cycle checks just before the edge, return at edge+1.
    task automatic cyc();
        logic [15:0] e;
        #1;
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && fifo_empty) chk("rd_en_while_empty", 32'(1), 32'(0));
        if (dut.r_occ > 2'd2) chk("occ_overflow", 32'(dut.r_occ), 32'(2));
        if (m_valid && m_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("stream_data", 32'(m_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input logic toggle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            if (toggle) m_ready = n[0];
            cyc();
            n++;
        end
        m_ready = 1'b1;
        chk("drain_done", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int rd0;
        int pop0;
        rst     = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();

        // 1: eight words, consumer always ready
        for (int i = 1; i <= 8; i++) push(16'(i));
        #1;
        chk("t1_rd_n", 32'(fifo_rd_en), 32'(1));
        chk("t1_valid_n", 32'(m_valid), 32'(0));
        cyc();
        chk("t1_rd_n1", 32'(fifo_rd_en), 32'(1));
        chk("t1_valid_n1", 32'(m_valid), 32'(0));
        cyc();
        chk("t1_valid_n2", 32'(m_valid), 32'(1));
        chk("t1_data_n2", 32'(m_data), 32'h0001);
        for (int i = 2; i < 8; i++) begin
            chk("t1_rd_burst", 32'(fifo_rd_en), 32'(1));
            chk("t1_valid_burst", 32'(m_valid), 32'(1));
            cyc();
        end
        chk("t1_rd_end", 32'(fifo_rd_en), 32'(0));
        drain(20, 1'b0);
        chk("t1_idle", 32'(m_valid), 32'(0));

        // 2: consumer stalled for 10 cycles
        m_ready = 1'b0;
        rd0 = rd_cnt;
        for (int i = 1; i <= 8; i++) push(16'(i));
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                #1;
                chk("t2_stall_valid", 32'(m_valid), 32'(1));
                chk("t2_stall_data", 32'(m_data), 32'h0001);
            end
            cyc();
        end
        chk("t2_stall_reads", 32'(rd_cnt - rd0), 32'(2));
        m_ready = 1'b1;
        #1;
        chk("t2_resume_rd", 32'(fifo_rd_en), 32'(1));
        drain(30, 1'b0);
        chk("t2_idle", 32'(m_valid), 32'(0));

        // 3: m_ready toggling every cycle
        pop0 = pop_cnt;
        for (int i = 1; i <= 8; i++) push(16'(16'h0100 + i));
        drain(60, 1'b1);
        chk("t3_pops", 32'(pop_cnt - pop0), 32'(8));

        // 4: single word
        rd0  = rd_cnt;
        pop0 = pop_cnt;
        push(16'hBEEF);
        for (int i = 0; i < 6; i++) cyc();
        chk("t4_reads", 32'(rd_cnt - rd0), 32'(1));
        chk("t4_pops", 32'(pop_cnt - pop0), 32'(1));
        chk("t4_idle", 32'(m_valid), 32'(0));

        // 5: reset with the buffer full
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'(16'h0010 + i));
        for (int i = 0; i < 5; i++) cyc();
        chk("t5_occ_full", 32'(dut.r_occ), 32'(2));
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(m_valid), 32'(0));
        chk("t5_rst_data", 32'(m_data), 32'(0));
        chk("t5_rst_rd", 32'(fifo_rd_en), 32'(0));
        exp_q.delete();
        pop_cnt = 0;
        @(posedge clk); #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) push(16'(16'h00A0 + i));
        drain(20, 1'b0);
        chk("t5_pops", 32'(pop_cnt), 32'(4));
        chk("t5_idle", 32'(m_valid), 32'(0));

`ifdef FIFO_RDR_STATS_EN
        // 6: counter tracks pops since reset, then wraps after 65537 pops
        chk("t6_count", 32'(word_count), 32'(4));
        rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(word_count), 32'(0));
        exp_q.delete();
        pop_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int pushed;
            int n;
            pushed = 0;
            n = 0;
            while (pop_cnt < 65537 && n < 66000) begin
                if (pushed < 65537 && exp_q.size() < 8) begin
                    push(16'(pushed));
                    pushed++;
                end
                cyc();
                n++;
            end
        end
        chk("t6_pops", 32'(pop_cnt), 32'(65537));
        chk("t6_wrap", 32'(word_count), 32'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
